// File: rtl/l1_mem_pkg.sv
// -----------------------------------------------------------------------------
// l1_mem_pkg
// Shared definitions for the L1-to-memory request path. The arbiter and both
// L1 cache FSMs import this package so state, size and owner encodings agree.
//   arb_state_t : arbiter FSM states (IDLE, ADDR, WAIT_DATA)
//   SIZE_*      : access size codes carried on *_mem_size
//   OWN_*       : requester identifiers used for owner/last tracking
// -----------------------------------------------------------------------------
package l1_mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR      = 2'd1,
        WAIT_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/l1_mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way picker used by the L1 memory arbiter.
//   req[0] : Icache requesting        req[1] : Dcache requesting
//   last   : requester that won the previous accepted transaction
//   mode   : 0 = round-robin, 1 = fixed priority (Dcache wins ties)
//   grant  : selected requester (OWN_I / OWN_D); OWN_I when nobody requests
// -----------------------------------------------------------------------------
module rr_arb2
    import l1_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       mode,
    output logic       grant
);

    always_comb begin
        grant = OWN_I;
        case (req)
            2'b01:   grant = OWN_I;
            2'b10:   grant = OWN_D;
            // On a tie round-robin hands the bus to whoever did not win last.
            2'b11:   grant = mode ? OWN_D : ~last;
            default: grant = OWN_I;
        endcase
    end

endmodule

// File: rtl/l1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// l1_mem_arbiter
// Shares the single L1-to-memory bus between the Icache miss path and the
// Dcache miss/writeback path, one outstanding transaction at a time.
// The winning request is forwarded combinationally so an uncontended miss
// sees no extra cycle; addrOK/dataOK are routed only to the owning cache.
//
// Parameters
//   ARB_MODE : 0 = round-robin, 1 = fixed priority with Dcache winning
//   ADDR_W   : address width
//   DATA_W   : data width (one word per transaction)
// Ports
//   clk, rstn                : clock, asynchronous active-low reset
//   icache_mem_*             : Icache read request (req/size/addr)
//   mem_icache_*             : Icache addrOK/dataOK/rdata
//   dcache_mem_*             : Dcache request (req/wr/size/addr/wdata)
//   mem_dcache_*             : Dcache addrOK/dataOK/rdata
//   mem_req..mem_wdata       : request driven onto the memory bus
//   mem_addrOK, mem_dataOK   : bus accept / completion
//   mem_rdata                : bus read data, broadcast to both caches
// -----------------------------------------------------------------------------
module l1_mem_arbiter
    import l1_mem_pkg::*;
#(
    parameter int ARB_MODE = 0,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              icache_mem_req,
    input  logic [1:0]        icache_mem_size,
    input  logic [ADDR_W-1:0] icache_mem_addr,
    output logic              mem_icache_addrOK,
    output logic              mem_icache_dataOK,
    output logic [DATA_W-1:0] mem_icache_rdata,

    input  logic              dcache_mem_req,
    input  logic              dcache_mem_wr,
    input  logic [1:0]        dcache_mem_size,
    input  logic [ADDR_W-1:0] dcache_mem_addr,
    input  logic [DATA_W-1:0] dcache_mem_wdata,
    output logic              mem_dcache_addrOK,
    output logic              mem_dcache_dataOK,
    output logic [DATA_W-1:0] mem_dcache_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addrOK,
    input  logic              mem_dataOK,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic MODE_FIXED = (ARB_MODE != 0);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q,  last_d;

    logic       grant;
    logic       any_req;
    logic       sel;        // requester whose fields drive the bus this cycle
    logic       fwd;        // a request is being forwarded this cycle
    logic       ack_addr;   // address phase accepted this cycle
    logic       ack_data;   // data phase completed this cycle

    assign any_req = icache_mem_req | dcache_mem_req;

    rr_arb2 u_pick (
        .req   ({dcache_mem_req, icache_mem_req}),
        .last  (last_q),
        .mode  (MODE_FIXED),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_D;   // Icache takes the first tie after reset
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        sel      = owner_q;
        fwd      = 1'b0;
        ack_addr = 1'b0;
        ack_data = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel     = grant;
                    fwd     = 1'b1;
                    owner_d = grant;
                    if (mem_addrOK) begin
                        ack_addr = 1'b1;
                        last_d   = grant;
                        state_d  = WAIT_DATA;
                    end else begin
                        state_d  = ADDR;
                    end
                end
            end
            ADDR: begin
                // Grant is locked to owner_q; a dropped req is still forwarded
                // (as 0) rather than handing the bus to the other cache.
                fwd = 1'b1;
                if (mem_addrOK) begin
                    ack_addr = 1'b1;
                    last_d   = owner_q;
                    state_d  = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (mem_dataOK) begin
                    ack_data = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_req           = fwd & (sel ? dcache_mem_req : icache_mem_req);
        mem_wr            = fwd & sel & dcache_mem_wr;
        mem_size          = fwd ? (sel ? dcache_mem_size : icache_mem_size) : SIZE_B;
        mem_addr          = fwd ? (sel ? dcache_mem_addr : icache_mem_addr) : '0;
        mem_wdata         = (fwd & sel) ? dcache_mem_wdata : '0;

        mem_icache_addrOK = ack_addr & (sel == OWN_I);
        mem_dcache_addrOK = ack_addr & (sel == OWN_D);
        mem_icache_dataOK = ack_data & (owner_q == OWN_I);
        mem_dcache_dataOK = ack_data & (owner_q == OWN_D);
    end

    assign mem_icache_rdata = mem_rdata;
    assign mem_dcache_rdata = mem_rdata;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
module tb_l1_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;

    logic        icache_mem_req;
    logic [1:0]  icache_mem_size;
    logic [31:0] icache_mem_addr;
    logic        dcache_mem_req;
    logic        dcache_mem_wr;
    logic [1:0]  dcache_mem_size;
    logic [31:0] dcache_mem_addr;
    logic [31:0] dcache_mem_wdata;
    logic        mem_addrOK;
    logic        mem_dataOK;
    logic [31:0] mem_rdata;

    // round-robin instance outputs
    logic        rr_i_aok, rr_i_dok, rr_d_aok, rr_d_dok;
    logic [31:0] rr_i_rdata, rr_d_rdata;
    logic        rr_req, rr_wr;
    logic [1:0]  rr_size;
    logic [31:0] rr_addr, rr_wdata;

    // fixed-priority instance outputs
    logic        fp_i_aok, fp_i_dok, fp_d_aok, fp_d_dok;
    logic [31:0] fp_i_rdata, fp_d_rdata;
    logic        fp_req, fp_wr;
    logic [1:0]  fp_size;
    logic [31:0] fp_addr, fp_wdata;

    logic        sel = 1'b0;  // 0 observes round-robin instance, 1 fixed-priority

    logic        o_i_aok, o_i_dok, o_d_aok, o_d_dok;
    logic [31:0] o_i_rdata, o_d_rdata;
    logic        o_req, o_wr;
    logic [1:0]  o_size;
    logic [31:0] o_addr, o_wdata;

    assign o_i_aok   = sel ? fp_i_aok   : rr_i_aok;
    assign o_i_dok   = sel ? fp_i_dok   : rr_i_dok;
    assign o_d_aok   = sel ? fp_d_aok   : rr_d_aok;
    assign o_d_dok   = sel ? fp_d_dok   : rr_d_dok;
    assign o_i_rdata = sel ? fp_i_rdata : rr_i_rdata;
    assign o_d_rdata = sel ? fp_d_rdata : rr_d_rdata;
    assign o_req     = sel ? fp_req     : rr_req;
    assign o_wr      = sel ? fp_wr      : rr_wr;
    assign o_size    = sel ? fp_size    : rr_size;
    assign o_addr    = sel ? fp_addr    : rr_addr;
    assign o_wdata   = sel ? fp_wdata   : rr_wdata;

    l1_mem_arbiter #(.ARB_MODE(0), .ADDR_W(32), .DATA_W(32)) u_dut (
        .clk(clk), .rstn(rstn),
        .icache_mem_req(icache_mem_req), .icache_mem_size(icache_mem_size),
        .icache_mem_addr(icache_mem_addr),
        .mem_icache_addrOK(rr_i_aok), .mem_icache_dataOK(rr_i_dok),
        .mem_icache_rdata(rr_i_rdata),
        .dcache_mem_req(dcache_mem_req), .dcache_mem_wr(dcache_mem_wr),
        .dcache_mem_size(dcache_mem_size), .dcache_mem_addr(dcache_mem_addr),
        .dcache_mem_wdata(dcache_mem_wdata),
        .mem_dcache_addrOK(rr_d_aok), .mem_dcache_dataOK(rr_d_dok),
        .mem_dcache_rdata(rr_d_rdata),
        .mem_req(rr_req), .mem_wr(rr_wr), .mem_size(rr_size),
        .mem_addr(rr_addr), .mem_wdata(rr_wdata),
        .mem_addrOK(mem_addrOK), .mem_dataOK(mem_dataOK), .mem_rdata(mem_rdata)
    );

    l1_mem_arbiter #(.ARB_MODE(1), .ADDR_W(32), .DATA_W(32)) u_dut_fp (
        .clk(clk), .rstn(rstn),
        .icache_mem_req(icache_mem_req), .icache_mem_size(icache_mem_size),
        .icache_mem_addr(icache_mem_addr),
        .mem_icache_addrOK(fp_i_aok), .mem_icache_dataOK(fp_i_dok),
        .mem_icache_rdata(fp_i_rdata),
        .dcache_mem_req(dcache_mem_req), .dcache_mem_wr(dcache_mem_wr),
        .dcache_mem_size(dcache_mem_size), .dcache_mem_addr(dcache_mem_addr),
        .dcache_mem_wdata(dcache_mem_wdata),
        .mem_dcache_addrOK(fp_d_aok), .mem_dcache_dataOK(fp_d_dok),
        .mem_dcache_rdata(fp_d_rdata),
        .mem_req(fp_req), .mem_wr(fp_wr), .mem_size(fp_size),
        .mem_addr(fp_addr), .mem_wdata(fp_wdata),
        .mem_addrOK(mem_addrOK), .mem_dataOK(mem_dataOK), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Scoreboard: every dataOK pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rstn) begin
            checks++;
            if ((o_i_aok && o_i_dok) || (o_d_aok && o_d_dok)) begin
                errors++;
                $display("FAIL pulse_rule got iaok=%0b idok=%0b daok=%0b ddok=%0b want no same-cache overlap",
                         o_i_aok, o_i_dok, o_d_aok, o_d_dok);
            end
            if (o_i_dok || o_d_dok) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got idok=%0b ddok=%0b want no dataOK", o_i_dok, o_d_dok);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({o_d_dok, o_i_dok} !== (mon_e.is_d ? 2'b10 : 2'b01) ||
                        o_i_rdata !== mon_e.rdata || o_d_rdata !== mon_e.rdata) begin
                        errors++;
                        $display("FAIL sb_data got ddok/idok=%0b%0b rdata=%h/%h want is_d=%0b rdata=%h",
                                 o_d_dok, o_i_dok, o_i_rdata, o_d_rdata, mon_e.is_d, mon_e.rdata);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        icache_mem_req   = 1'b0;
        icache_mem_size  = 2'd0;
        icache_mem_addr  = 32'h0;
        dcache_mem_req   = 1'b0;
        dcache_mem_wr    = 1'b0;
        dcache_mem_size  = 2'd0;
        dcache_mem_addr  = 32'h0;
        dcache_mem_wdata = 32'h0;
        mem_addrOK       = 1'b0;
        mem_dataOK       = 1'b0;
        mem_rdata        = 32'h0;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    // One transaction with addrOK in the grant cycle and dataOK the next cycle.
    task automatic round(input logic ir, input logic dr, input logic exp_d,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] rd, input string name);
        step();
        icache_mem_req  = ir;
        icache_mem_addr = ia;
        icache_mem_size = 2'd2;
        dcache_mem_req  = dr;
        dcache_mem_addr = da;
        dcache_mem_size = 2'd2;
        dcache_mem_wr   = 1'b0;
        mem_addrOK      = 1'b1;
        mem_dataOK      = 1'b0;
        #3;
        checks++;
        if (o_i_aok !== ~exp_d || o_d_aok !== exp_d) begin
            errors++;
            $display("FAIL %s_grant got iaok=%0b daok=%0b want dcache_wins=%0b", name, o_i_aok, o_d_aok, exp_d);
        end
        checks++;
        if (o_req !== 1'b1 || o_addr !== (exp_d ? da : ia)) begin
            errors++;
            $display("FAIL %s_fwd got req=%0b addr=%h want req=1 addr=%h", name, o_req, o_addr, exp_d ? da : ia);
        end
        sb_q.push_back('{exp_d, rd});
        step();
        if (exp_d) dcache_mem_req = 1'b0;
        else       icache_mem_req = 1'b0;
        mem_addrOK = 1'b0;
        mem_dataOK = 1'b1;
        mem_rdata  = rd;
        #3;
        checks++;
        if (o_req !== 1'b0 || o_i_dok !== ~exp_d || o_d_dok !== exp_d || o_i_aok !== 1'b0 || o_d_aok !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got req=%0b idok=%0b ddok=%0b iaok=%0b daok=%0b want req=0 dcache_done=%0b",
                     name, o_req, o_i_dok, o_d_dok, o_i_aok, o_d_aok, exp_d);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        step();
        #3;
        checks++;
        if (o_req !== 1'b0 || o_wr !== 1'b0 || o_size !== 2'd0 || o_addr !== 32'h0 || o_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got req=%0b wr=%0b size=%0d addr=%h wdata=%h want all 0",
                     o_req, o_wr, o_size, o_addr, o_wdata);
        end
        checks++;
        if ({o_i_aok, o_i_dok, o_d_aok, o_d_dok} !== 4'b0) begin
            errors++;
            $display("FAIL reset_acks got %b want 0000", {o_i_aok, o_i_dok, o_d_aok, o_d_dok});
        end
        step();
        rstn = 1'b1;
    endtask

    task automatic test_icache_read();
        step();
        idle_inputs();
        icache_mem_req   = 1'b1;
        icache_mem_addr  = 32'h1000;
        icache_mem_size  = 2'd2;
        dcache_mem_wr    = 1'b1;          // idle Dcache fields must not leak
        dcache_mem_wdata = 32'hFFFF_FFFF;
        dcache_mem_addr  = 32'hFFFF_0000;
        mem_addrOK       = 1'b1;
        #3;
        checks++;
        if (o_req !== 1'b1 || o_addr !== 32'h1000 || o_size !== 2'd2 || o_wr !== 1'b0 || o_wdata !== 32'h0) begin
            errors++;
            $display("FAIL iread_fwd got req=%0b addr=%h size=%0d wr=%0b wdata=%h want 1 00001000 2 0 0",
                     o_req, o_addr, o_size, o_wr, o_wdata);
        end
        checks++;
        if (o_i_aok !== 1'b1 || o_d_aok !== 1'b0) begin
            errors++;
            $display("FAIL iread_aok got iaok=%0b daok=%0b want 1 0", o_i_aok, o_d_aok);
        end
        sb_q.push_back('{1'b0, 32'hDEAD_BEEF});
        step();
        icache_mem_req = 1'b0;            // addrOK stays high: ignored in WAIT_DATA
        #3;
        checks++;
        if (o_req !== 1'b0 || o_i_aok !== 1'b0 || o_d_aok !== 1'b0) begin
            errors++;
            $display("FAIL iread_wait got req=%0b iaok=%0b daok=%0b want 0 0 0", o_req, o_i_aok, o_d_aok);
        end
        step();
        mem_addrOK = 1'b0;
        #3;
        checks++;
        if (o_i_dok !== 1'b0 || o_d_dok !== 1'b0) begin
            errors++;
            $display("FAIL iread_early got idok=%0b ddok=%0b want 0 0", o_i_dok, o_d_dok);
        end
        step();
        mem_dataOK = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #3;
        checks++;
        if (o_i_dok !== 1'b1 || o_d_dok !== 1'b0 || o_i_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL iread_done got idok=%0b ddok=%0b rdata=%h want 1 0 deadbeef", o_i_dok, o_d_dok, o_i_rdata);
        end
        step();                           // dataOK held high: ignored in IDLE
        #3;
        checks++;
        if (o_i_dok !== 1'b0 || o_d_dok !== 1'b0) begin
            errors++;
            $display("FAIL iread_stray got idok=%0b ddok=%0b want 0 0", o_i_dok, o_d_dok);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_rr_tie();
        sel = 1'b0;
        do_reset();
        round(1'b1, 1'b1, 1'b0, 32'h0000_1100, 32'h0000_2200, 32'h1111_0001, "rr1");
        round(1'b1, 1'b1, 1'b1, 32'h0000_1104, 32'h0000_2204, 32'h2222_0002, "rr2");
        round(1'b1, 1'b1, 1'b0, 32'h0000_1108, 32'h0000_2208, 32'h3333_0003, "rr3");
        round(1'b1, 1'b1, 1'b1, 32'h0000_110C, 32'h0000_220C, 32'h4444_0004, "rr4");
        step();
        idle_inputs();
    endtask

    task automatic test_fixed_priority();
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 3; i++)
            round(1'b1, 1'b1, 1'b1, 32'h0000_A000 + i, 32'h0000_B000 + i, 32'h5A00_0000 + i, "fp_tie");
        round(1'b1, 1'b0, 1'b0, 32'h0000_A100, 32'h0000_B100, 32'h5A00_0100, "fp_ionly");
        round(1'b1, 1'b1, 1'b1, 32'h0000_A200, 32'h0000_B200, 32'h5A00_0200, "fp_tie2");
        step();
        idle_inputs();
        sel = 1'b0;
    endtask

    task automatic test_delayed_addrok();
        do_reset();
        step();
        icache_mem_req  = 1'b1;
        icache_mem_addr = 32'h0000_3000;
        icache_mem_size = 2'd2;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin
                dcache_mem_req  = 1'b1;
                dcache_mem_addr = 32'h0000_4000;
                dcache_mem_size = 2'd2;
            end
            #3;
            checks++;
            if (o_req !== 1'b1 || o_addr !== 32'h0000_3000 || o_i_aok !== 1'b0 || o_d_aok !== 1'b0) begin
                errors++;
                $display("FAIL dly_hold%0d got req=%0b addr=%h iaok=%0b daok=%0b want 1 00003000 0 0",
                         c, o_req, o_addr, o_i_aok, o_d_aok);
            end
            step();
        end
        mem_addrOK = 1'b1;
        #3;
        checks++;
        if (o_i_aok !== 1'b1 || o_d_aok !== 1'b0 || o_addr !== 32'h0000_3000) begin
            errors++;
            $display("FAIL dly_accept got iaok=%0b daok=%0b addr=%h want 1 0 00003000", o_i_aok, o_d_aok, o_addr);
        end
        sb_q.push_back('{1'b0, 32'hA5A5_0003});
        step();
        icache_mem_req = 1'b0;
        mem_addrOK     = 1'b0;
        mem_dataOK     = 1'b1;
        mem_rdata      = 32'hA5A5_0003;
        #3;
        checks++;
        if (o_i_dok !== 1'b1 || o_d_dok !== 1'b0) begin
            errors++;
            $display("FAIL dly_done got idok=%0b ddok=%0b want 1 0", o_i_dok, o_d_dok);
        end
        round(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_4000, 32'hA5A5_0004, "dly_next");
        step();
        idle_inputs();
    endtask

    task automatic test_dcache_write();
        step();
        idle_inputs();
        dcache_mem_req   = 1'b1;
        dcache_mem_wr    = 1'b1;
        dcache_mem_wdata = 32'h1234_5678;
        dcache_mem_addr  = 32'h0000_2004;
        dcache_mem_size  = 2'd2;
        icache_mem_addr  = 32'h0000_5555;
        mem_addrOK       = 1'b1;
        #3;
        checks++;
        if (o_wr !== 1'b1 || o_wdata !== 32'h1234_5678 || o_addr !== 32'h0000_2004 || o_req !== 1'b1) begin
            errors++;
            $display("FAIL dwr_fwd got wr=%0b wdata=%h addr=%h req=%0b want 1 12345678 00002004 1",
                     o_wr, o_wdata, o_addr, o_req);
        end
        checks++;
        if (o_d_aok !== 1'b1 || o_i_aok !== 1'b0) begin
            errors++;
            $display("FAIL dwr_aok got daok=%0b iaok=%0b want 1 0", o_d_aok, o_i_aok);
        end
        sb_q.push_back('{1'b1, 32'h0BAD_F00D});
        step();
        dcache_mem_req = 1'b0;
        mem_addrOK     = 1'b0;
        step();
        step();
        mem_dataOK = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
        #3;
        checks++;
        if (o_d_dok !== 1'b1 || o_i_dok !== 1'b0) begin
            errors++;
            $display("FAIL dwr_ack got ddok=%0b idok=%0b want 1 0", o_d_dok, o_i_dok);
        end
        step();
        mem_dataOK = 1'b0;
        #3;
        checks++;
        if (o_d_dok !== 1'b0) begin
            errors++;
            $display("FAIL dwr_once got ddok=%0b want 0", o_d_dok);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        step();
        idle_inputs();
        icache_mem_req  = 1'b1;
        icache_mem_addr = 32'h0000_6000;
        mem_addrOK      = 1'b1;
        #3;
        checks++;
        if (o_i_aok !== 1'b1) begin
            errors++;
            $display("FAIL rmid_grant got iaok=%0b want 1", o_i_aok);
        end
        step();
        icache_mem_req = 1'b0;
        mem_addrOK     = 1'b0;
        #3;
        checks++;
        if (o_req !== 1'b0) begin
            errors++;
            $display("FAIL rmid_wait got req=%0b want 0", o_req);
        end
        step();
        #1;
        rstn       = 1'b0;
        mem_dataOK = 1'b1;
        #2;
        checks++;
        if ({o_i_aok, o_i_dok, o_d_aok, o_d_dok, o_req, o_wr} !== 6'b0 || o_addr !== 32'h0) begin
            errors++;
            $display("FAIL rmid_async got acks/req/wr=%b addr=%h want 000000 00000000",
                     {o_i_aok, o_i_dok, o_d_aok, o_d_dok, o_req, o_wr}, o_addr);
        end
        step();
        rstn = 1'b1;
        #3;
        checks++;
        if (o_i_dok !== 1'b0 || o_d_dok !== 1'b0) begin
            errors++;
            $display("FAIL rmid_stray got idok=%0b ddok=%0b want 0 0", o_i_dok, o_d_dok);
        end
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_icache_read();
        test_rr_tie();
        test_fixed_priority();
        test_delayed_addrok();
        test_dcache_write();
        test_reset_mid();
        step();
        step();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
